// File: rtl/alu_issue_unit.sv
// Issue/writeback sequencer in front of a combinational ALU: operand register file,
// valid/ready instruction intake, and result writeback. `ALU_ISSUE_FAST_EN drops the WB state.
module alu_issue_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS),
  localparam int unsigned IW = 3 + 3 * AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [WIDTH-1:0] ld_data_i,
  output logic             ld_ready_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IW-1:0]    in_instr_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             wb_valid_o,
  output logic [AW-1:0]    wb_rd_o,
  output logic [WIDTH-1:0] wb_data_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, wb_data_q;
  logic [2:0]       alu_op_q;
  logic             in_ready_q, ld_ready_q, wb_valid_q;
  logic [AW-1:0]    wb_rd_q;

  logic [2:0]       instr_op;
  logic [AW-1:0]    instr_rd, instr_rs1, instr_rs2;
  logic [WIDTH-1:0] opnd_a, opnd_b;

  assign instr_op  = in_instr_i[IW-1 -: 3];
  assign instr_rd  = in_instr_i[3*AW-1 -: AW];
  assign instr_rs1 = in_instr_i[2*AW-1 -: AW];
  assign instr_rs2 = in_instr_i[AW-1:0];

  // Operands are fetched at the accept edge; forward a same-cycle load so the
  // instruction observes the freshly loaded value.
  assign opnd_a = (ld_en_i && (ld_addr_i == instr_rs1)) ? ld_data_i : rf_q[instr_rs1];
  assign opnd_b = (ld_en_i && (ld_addr_i == instr_rs2)) ? ld_data_i : rf_q[instr_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      in_ready_q <= 1'b1;
      ld_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_en_i) rf_q[ld_addr_i] <= ld_data_i;
          if (in_valid_i) begin
            alu_a_q    <= opnd_a;
            alu_b_q    <= opnd_b;
            alu_op_q   <= instr_op;
            rd_q       <= instr_rd;
            in_ready_q <= 1'b0;
            ld_ready_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // wb_data_q doubles as the captured ALU result
          wb_valid_q <= 1'b1;
          wb_rd_q    <= rd_q;
          wb_data_q  <= alu_result_i;
`ifdef ALU_ISSUE_FAST_EN
          rf_q[rd_q] <= alu_result_i;
          in_ready_q <= 1'b1;
          ld_ready_q <= 1'b1;
          state_q    <= IDLE;
`else
          state_q    <= WB;
`endif
        end
        WB: begin
          rf_q[rd_q] <= wb_data_q;
          in_ready_q <= 1'b1;
          ld_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign ld_ready_o = ld_ready_q;
  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_op_o   = alu_op_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: transaction-level reference model plus directed vectors.
// Honours `ALU_ISSUE_FAST_EN for throughput expectations.
module tb_alu_issue_unit;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREGS = 4;
  localparam int unsigned AW    = 2;
`ifdef ALU_ISSUE_FAST_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld_en = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             ld_ready;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3+3*AW-1:0] in_instr = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_op;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [WIDTH-1:0] wb_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wb_pulses = 0;

  alu_issue_unit #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_result),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && wb_valid) wb_pulses++;

  // Stand-in ALU: 000 add, 001 sub, 010 and, 011 or, 100 xnor, others pass a.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~(a ^ b);
      default: return a;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks each instruction by how many cycles have passed since it was accepted.
  int               m_age;
  logic [3:0]       m_rf [NREGS];
  logic [3:0]       m_a, m_b, m_res, m_wbd;
  logic [2:0]       m_op;
  logic [AW-1:0]    m_rd, m_wbrd;
  logic             m_wbv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age = -1;
      for (int i = 0; i < int'(NREGS); i++) m_rf[i] = '0;
      m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_res = '0;
      m_wbv = 1'b0; m_wbrd = '0; m_wbd = '0;
    end else begin
      m_wbv = 1'b0;
      if (m_age == 0) begin
        m_res = alu_result;
        m_wbv = 1'b1; m_wbrd = m_rd; m_wbd = m_res;
`ifdef ALU_ISSUE_FAST_EN
        m_rf[m_rd] = m_res;
        m_age = -1;
`else
        m_age = 1;
`endif
      end else if (m_age == 1) begin
        m_rf[m_rd] = m_res;
        m_age = -1;
      end else begin
        if (ld_en) m_rf[ld_addr] = ld_data;
        if (in_valid) begin
          logic [2:0] op; logic [AW-1:0] rd, rs1, rs2;
          {op, rd, rs1, rs2} = in_instr;
          m_op = op; m_rd = rd; m_a = m_rf[rs1]; m_b = m_rf[rs2];
          m_age = 0;
        end
      end
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_age < 0);
      chk("ld_ready", ld_ready, m_age < 0);
      chk("wb_valid", wb_valid, m_wbv);
      chk("wb_rd", wb_rd, m_wbrd);
      chk("wb_data", wb_data, m_wbd);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present an instruction and return just after the edge that accepts it (ISSUE cycle).
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit ok = 0;
    in_valid = 1'b1;
    in_instr = {op, rd, rs1, rs2};
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  int acc [3];
  int p0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    send(3'b000, 2'd3, 2'd0, 2'd1);
    chk("rst_rf_a", alu_a, 4'h0);
    chk("rst_rf_b", alu_b, 4'h0);
    chk("issue_in_ready", in_ready, 0);
    wait_idle();

    // Basic add with writeback and dependent read
    load(2'd0, 4'b1011);
    load(2'd1, 4'b1001);
    send(3'b000, 2'd2, 2'd0, 2'd1);
    chk("add_a", alu_a, 4'b1011);
    chk("add_b", alu_b, 4'b1001);
    chk("add_op", alu_op, 3'b000);
    step();
    chk("add_wbv", wb_valid, 1);
    chk("add_wbrd", wb_rd, 2'd2);
    chk("add_wbd", wb_data, 4'b0100);
    wait_idle();
    send(3'b000, 2'd3, 2'd2, 2'd0);
    chk("dep_a", alu_a, 4'b0100);
    wait_idle();

    // Aliasing rd == rs1 == rs2
    load(2'd3, 4'b1101);
    send(3'b100, 2'd3, 2'd3, 2'd3);
    chk("alias_a", alu_a, 4'b1101);
    chk("alias_b", alu_b, 4'b1101);
    step();
    chk("alias_wbd", wb_data, 4'b1111);
    wait_idle();
    send(3'b000, 2'd1, 2'd3, 2'd3);
    chk("alias_r3", alu_a, 4'b1111);
    wait_idle();

    // Load during ISSUE is ignored
    send(3'b010, 2'd1, 2'd0, 2'd0);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'b0001;
    step();
    ld_en = 1'b0;
    wait_idle();
    send(3'b000, 2'd2, 2'd0, 2'd0);
    chk("ld_ignored_r0", alu_a, 4'b1011);
    wait_idle();

    // Load and accept on the same edge
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'b0110;
    send(3'b011, 2'd2, 2'd1, 2'd0);
    ld_en = 1'b0;
    chk("ld_fwd_a", alu_a, 4'b0110);
    chk("ld_fwd_b", alu_b, 4'b1011);
    wait_idle();
    step();

    // Back-to-back with in_valid held high
    p0 = wb_pulses;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit ok = 0;
      in_instr = {3'(k), 2'(k), 2'd0, 2'd1};
      for (int i = 0; i < 20; i++) begin
        if (in_ready) begin ok = 1; break; end
        step();
      end
      if (!ok) chk("b2b_timeout", 0, 1);
      step();
      acc[k] = cyc;
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (3) step();
    chk("b2b_gap01", acc[1] - acc[0], GAP);
    chk("b2b_gap12", acc[2] - acc[1], GAP);
    chk("b2b_pulses", wb_pulses - p0, 3);

    // Reset mid-ISSUE aborts the instruction
    send(3'b011, 2'd3, 2'd0, 2'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_wbv", wb_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    p0 = wb_pulses;
    repeat (3) step();
    chk("abort_no_wb", wb_pulses - p0, 0);
    send(3'b000, 2'd0, 2'd3, 2'd3);
    chk("abort_rd_zero", alu_a, 4'h0);
    wait_idle();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
